// File: rtl/elevator_pkg.sv
// Shared command/sensor encodings and FSM state types for the elevator shaft plant model.
package elevator_pkg;

  localparam logic [1:0] ENGINE_STOP    = 2'b00;
  localparam logic [1:0] ENGINE_UP      = 2'b01;
  localparam logic [1:0] ENGINE_DOWN    = 2'b10;
  localparam logic [1:0] ENGINE_ILLEGAL = 2'b11;

  localparam logic [1:0] DOOR_HOLD    = 2'b00;
  localparam logic [1:0] DOOR_OPEN    = 2'b01;
  localparam logic [1:0] DOOR_CLOSE   = 2'b10;
  localparam logic [1:0] DOOR_ILLEGAL = 2'b11;

  localparam logic [1:0] SDOOR_CLOSED = 2'b10;
  localparam logic [1:0] SDOOR_OPEN   = 2'b01;
  localparam logic [1:0] SDOOR_MOVING = 2'b00;

  typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DN} pos_state_t;
  typedef enum logic [1:0] {CLOSED, OPENING, OPEN, CLOSING} door_state_t;

endpackage

// File: rtl/door_actuator_model.sv
// Door actuator plant: door FSM, travel counter and sensor_door encoding.
// Define DOOR_OBSTRUCT_EN to add the obstruct input (reopen while closing).
module door_actuator_model
  import elevator_pkg::*;
#(
  parameter int DOOR_TICKS = 600,
  localparam int CNT_W = $clog2(DOOR_TICKS + 1)
) (
  input  logic        clock,
  input  logic        an_reset,
  input  logic [1:0]  door,
  input  logic        car_moving,
`ifdef DOOR_OBSTRUCT_EN
  input  logic        obstruct,
`endif
  output logic [1:0]  sensor_door,
  output logic        door_closed,
  output logic        door_fault,
  output door_state_t door_state
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DOOR_TICKS);

  door_state_t      state_q, state_next;
  logic [CNT_W-1:0] cnt_q, cnt_next;
  logic [1:0]       cmd;
`ifdef DOOR_OBSTRUCT_EN
  logic             obs_q, obs_next;
`endif

  function automatic logic [CNT_W-1:0] cnt_up(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] cnt_dn(input logic [CNT_W-1:0] c);
    return (c == '0) ? c : c - CNT_W'(1);
  endfunction

  assign door_closed = (cnt_q == '0);
  assign door_state  = state_q;

  always_comb begin
    cmd        = door;
    door_fault = 1'b0;
    cnt_next   = cnt_q;
    state_next = state_q;
    // Illegal codes and any command while the car moves are ignored and flagged.
    if (door == DOOR_ILLEGAL || (car_moving && door != DOOR_HOLD)) begin
      door_fault = 1'b1;
      cmd        = DOOR_HOLD;
    end
`ifdef DOOR_OBSTRUCT_EN
    obs_next = obs_q || (state_q == CLOSING && obstruct);
    if (obs_next) begin
      if (cnt_q == CNT_MAX && door != DOOR_OPEN) begin
        obs_next   = 1'b0;
        state_next = OPEN;
      end else begin
        cnt_next   = cnt_up(cnt_q);
        state_next = OPENING;
      end
    end else begin
`else
    begin
`endif
      case (cmd)
        DOOR_OPEN: begin
          cnt_next   = cnt_up(cnt_q);
          state_next = (cnt_next == CNT_MAX) ? OPEN : OPENING;
        end
        DOOR_CLOSE: begin
          cnt_next   = cnt_dn(cnt_q);
          state_next = (cnt_next == '0) ? CLOSED : CLOSING;
        end
        default: begin
          if (cnt_q == '0)          state_next = CLOSED;
          else if (cnt_q == CNT_MAX) state_next = OPEN;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (an_reset) begin
      state_q     <= CLOSED;
      cnt_q       <= '0;
      sensor_door <= SDOOR_CLOSED;
    end else begin
      state_q <= state_next;
      cnt_q   <= cnt_next;
      if (cnt_next == '0)           sensor_door <= SDOOR_CLOSED;
      else if (cnt_next == CNT_MAX) sensor_door <= SDOOR_OPEN;
      else                          sensor_door <= SDOOR_MOVING;
    end
  end

`ifdef DOOR_OBSTRUCT_EN
  always_ff @(posedge clock) begin
    if (an_reset) obs_q <= 1'b0;
    else          obs_q <= obs_next;
  end
`endif

endmodule

// File: rtl/elevator_shaft_model.sv
// Elevator car/shaft plant: position FSM, leveling-vane decode and sticky fault.
// Define DOOR_OBSTRUCT_EN to add the obstruct input on the door actuator.
module elevator_shaft_model
  import elevator_pkg::*;
#(
  parameter int BUTTONS_WIDTH = 8,
  parameter int FLOOR_TICKS   = 1000,
  parameter int ZONE_TICKS    = 50,
  parameter int MOVE_DIV      = 4,
  parameter int DOOR_TICKS    = 600,
  parameter int INIT_POS      = 0,
  localparam int FLOOR_W = $clog2(BUTTONS_WIDTH),
  localparam int POS_W   = $clog2((BUTTONS_WIDTH - 1) * FLOOR_TICKS + 1)
) (
  input  logic               clock,
  input  logic               an_reset,
  input  logic [1:0]         engine,
  input  logic [1:0]         door,
`ifdef DOOR_OBSTRUCT_EN
  input  logic               obstruct,
`endif
  output logic               sensor_up,
  output logic               sensor_down,
  output logic [1:0]         sensor_door,
  output logic [FLOOR_W-1:0] car_floor,
  output logic [POS_W-1:0]   car_pos,
  output logic               fault,
  output pos_state_t         dbg_pos_state,
  output door_state_t        dbg_door_state
);

  // Command interface has no valid/ready: engine and door are levels sampled
  // every clock and always accepted; sensors are levels updated every clock.

  localparam int OFF_W = $clog2(FLOOR_TICKS);
  localparam int PRE_W = $clog2(MOVE_DIV + 1);
  localparam logic [POS_W-1:0]   TOP_POS   = POS_W'((BUTTONS_WIDTH - 1) * FLOOR_TICKS);
  localparam logic [POS_W-1:0]   RST_POS   = POS_W'(INIT_POS);
  localparam logic [FLOOR_W-1:0] RST_FLOOR = FLOOR_W'(INIT_POS / FLOOR_TICKS);
  localparam logic [OFF_W-1:0]   RST_OFF   = OFF_W'(INIT_POS % FLOOR_TICKS);
  localparam logic [OFF_W-1:0]   OFF_LAST  = OFF_W'(FLOOR_TICKS - 1);
  localparam logic [OFF_W-1:0]   OFF_ZONE  = OFF_W'(ZONE_TICKS);
  localparam logic [OFF_W-1:0]   OFF_UPPER = OFF_W'(FLOOR_TICKS - ZONE_TICKS);
  localparam logic [PRE_W-1:0]   PRE_LAST  = PRE_W'(MOVE_DIV - 1);

  pos_state_t         pos_state, pos_next;
  logic [POS_W-1:0]   pos_q;
  logic [FLOOR_W-1:0] floor_q;
  logic [OFF_W-1:0]   off_q;
  logic [PRE_W-1:0]   pre_q, pre_eff, pre_next;
  logic               step, step_up, step_dn, pos_fault;
  logic               door_fault, door_closed, car_moving;

  always_comb begin
    pos_next  = IDLE;
    pos_fault = 1'b0;
    case (engine)
      ENGINE_STOP: ;
      ENGINE_UP:   if (door_closed) pos_next = MOVE_UP; else pos_fault = 1'b1;
      ENGINE_DOWN: if (door_closed) pos_next = MOVE_DN; else pos_fault = 1'b1;
      default:     pos_fault = 1'b1;
    endcase
    if (pos_next == MOVE_UP && pos_q == TOP_POS) pos_fault = 1'b1;
    if (pos_next == MOVE_DN && pos_q == '0)      pos_fault = 1'b1;
    // A state change restarts the prescaler, counting the current clock as the first.
    pre_eff  = (pos_next != pos_state) ? '0 : pre_q;
    step     = (pos_next != IDLE) && (pre_eff == PRE_LAST);
    pre_next = (pos_next == IDLE || step) ? '0 : pre_eff + PRE_W'(1);
    step_up  = step && (pos_next == MOVE_UP) && (pos_q != TOP_POS);
    step_dn  = step && (pos_next == MOVE_DN) && (pos_q != '0);
  end

  assign car_moving    = (pos_next != IDLE);
  assign car_pos       = pos_q;
  assign dbg_pos_state = pos_state;

  always_ff @(posedge clock) begin
    if (an_reset) begin
      pos_state <= IDLE;
      pre_q     <= '0;
      pos_q     <= RST_POS;
      floor_q   <= RST_FLOOR;
      off_q     <= RST_OFF;
      fault     <= 1'b0;
    end else begin
      pos_state <= pos_next;
      pre_q     <= pre_next;
      fault     <= fault | pos_fault | door_fault;
      if (step_up) begin
        pos_q <= pos_q + POS_W'(1);
        if (off_q == OFF_LAST) begin
          off_q   <= '0;
          floor_q <= floor_q + FLOOR_W'(1);
        end else begin
          off_q <= off_q + OFF_W'(1);
        end
      end else if (step_dn) begin
        pos_q <= pos_q - POS_W'(1);
        if (off_q == '0) begin
          off_q   <= OFF_LAST;
          floor_q <= floor_q - FLOOR_W'(1);
        end else begin
          off_q <= off_q - OFF_W'(1);
        end
      end
    end
  end

  // Vanes decode from the in-floor offset: offset 0 is level, the upper band
  // belongs to the vane of the floor above.
  always_ff @(posedge clock) begin
    sensor_up   <= (off_q == '0) || (off_q >= OFF_UPPER);
    sensor_down <= (off_q <= OFF_ZONE);
    car_floor   <= floor_q;
  end

  door_actuator_model #(
    .DOOR_TICKS(DOOR_TICKS)
  ) u_door (
    .clock       (clock),
    .an_reset    (an_reset),
    .door        (door),
    .car_moving  (car_moving),
`ifdef DOOR_OBSTRUCT_EN
    .obstruct    (obstruct),
`endif
    .sensor_door (sensor_door),
    .door_closed (door_closed),
    .door_fault  (door_fault),
    .door_state  (dbg_door_state)
  );

endmodule

// File: tb/tb_elevator_shaft_model.sv
// Bench for elevator_shaft_model: three plants (INIT_POS 0, 7000, 500) share one
// command stream; a behavioural model feeds an expected queue checked by a monitor.
module tb_elevator_shaft_model;
  import elevator_pkg::*;

  localparam int NDUT    = 3;
  localparam int BW      = 8;
  localparam int FT      = 1000;
  localparam int ZT      = 50;
  localparam int MD      = 4;
  localparam int DT      = 600;
  localparam int TOP     = (BW - 1) * FT;
  localparam int FLOOR_W = 3;
  localparam int POS_W   = 13;
  localparam int EW      = POS_W + FLOOR_W + 5;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       an_reset = 1'b1;
  logic [1:0] engine   = 2'b00;
  logic [1:0] door     = 2'b00;
`ifdef DOOR_OBSTRUCT_EN
  logic       obstruct = 1'b0;
`endif

  logic               sensor_up   [NDUT];
  logic               sensor_down [NDUT];
  logic [1:0]         sensor_door [NDUT];
  logic [FLOOR_W-1:0] car_floor   [NDUT];
  logic [POS_W-1:0]   car_pos     [NDUT];
  logic               fault       [NDUT];
  pos_state_t         dbg_ps      [NDUT];
  door_state_t        dbg_ds      [NDUT];
  logic [EW-1:0]      act         [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    elevator_shaft_model #(
      .BUTTONS_WIDTH(BW), .FLOOR_TICKS(FT), .ZONE_TICKS(ZT), .MOVE_DIV(MD),
      .DOOR_TICKS(DT), .INIT_POS((g == 0) ? 0 : (g == 1) ? 7000 : 500)
    ) u_dut (
      .clock          (clk),
      .an_reset       (an_reset),
      .engine         (engine),
      .door           (door),
`ifdef DOOR_OBSTRUCT_EN
      .obstruct       (obstruct),
`endif
      .sensor_up      (sensor_up[g]),
      .sensor_down    (sensor_down[g]),
      .sensor_door    (sensor_door[g]),
      .car_floor      (car_floor[g]),
      .car_pos        (car_pos[g]),
      .fault          (fault[g]),
      .dbg_pos_state  (dbg_ps[g]),
      .dbg_door_state (dbg_ds[g])
    );
    assign act[g] = {car_pos[g], car_floor[g], sensor_up[g], sensor_down[g],
                     sensor_door[g], fault[g]};
  end

  // scoreboard state
  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  // behavioural plant model
  int m_pos [NDUT];
  int m_door[NDUT];
  int m_run [NDUT];
  int m_dir [NDUT];
  bit m_fault[NDUT];

  function automatic int init_of(int i);
    return (i == 0) ? 0 : (i == 1) ? 7000 : 500;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NDUT; i++) begin
      m_pos[i] = init_of(i); m_door[i] = 0; m_run[i] = 0; m_dir[i] = 0; m_fault[i] = 1'b0;
    end
  endfunction

  function automatic bit vane_up(int p);
    for (int f = 0; f < BW; f++) if (p >= f * FT - ZT && p <= f * FT) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit vane_dn(int p);
    for (int f = 0; f < BW; f++) if (p >= f * FT && p <= f * FT + ZT) return 1'b1;
    return 1'b0;
  endfunction

  // Advances plant i by one clock with the given commands; returns the outputs after that edge.
  function automatic logic [EW-1:0] model_step(int i, logic [1:0] e, logic [1:0] d);
    int prev, dir;
    bit f;
    logic [1:0] dcode;
    prev = m_pos[i]; dir = 0; f = 1'b0;
    if (e == 2'b01) begin if (m_door[i] == 0) dir = 1; else f = 1'b1; end
    else if (e == 2'b10) begin if (m_door[i] == 0) dir = -1; else f = 1'b1; end
    else if (e == 2'b11) f = 1'b1;
    if ((dir == 1 && m_pos[i] == TOP) || (dir == -1 && m_pos[i] == 0)) f = 1'b1;
    if (dir != m_dir[i]) m_run[i] = 0;
    m_dir[i] = dir;
    if (dir != 0) begin
      m_run[i]++;
      if (m_run[i] % MD == 0 && !(dir == 1 && m_pos[i] == TOP) && !(dir == -1 && m_pos[i] == 0))
        m_pos[i] += dir;
    end
    if (d == 2'b11 || (d != 2'b00 && dir != 0)) f = 1'b1;
    else if (d == 2'b01 && m_door[i] < DT) m_door[i]++;
    else if (d == 2'b10 && m_door[i] > 0)  m_door[i]--;
    m_fault[i] = m_fault[i] | f;
    dcode = (m_door[i] == 0) ? 2'b10 : (m_door[i] == DT) ? 2'b01 : 2'b00;
    return {POS_W'(m_pos[i]), FLOOR_W'(prev / FT), vane_up(prev), vane_dn(prev), dcode, m_fault[i]};
  endfunction

  // driver tasks
  task automatic cycle(input logic [1:0] e, input logic [1:0] d);
    @(negedge clk);
    an_reset = 1'b0; engine = e; door = d;
    for (int i = 0; i < NDUT; i++) exp_q.push_back(model_step(i, e, d));
  endtask

  task automatic do_reset();
    @(negedge clk);
    an_reset = 1'b1; engine = ENGINE_STOP; door = DOOR_HOLD;
    @(negedge clk);
    model_reset();
  endtask

  task automatic settle();
    @(posedge clk);
    #3;
  endtask

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, actual, expected);
  endtask

  // monitor: pops one expectation per plant after every clock that had stimulus
  initial begin
    forever begin
      @(posedge clk);
      #2;
      for (int i = 0; i < NDUT; i++) begin
        if (exp_q.size() != 0) begin
          logic [EW-1:0] ex;
          ex = exp_q.pop_front();
          n_checks++;
          if (act[i] === ex) n_pass++;
          else $display("FAIL sb dut%0d t=%0t: got pos=%0d floor=%0d up=%b dn=%b door=%b fault=%b expected pos=%0d floor=%0d up=%b dn=%b door=%b fault=%b",
                        i, $time, act[i][20:8], act[i][7:5], act[i][4], act[i][3], act[i][2:1], act[i][0],
                        ex[20:8], ex[7:5], ex[4], ex[3], ex[2:1], ex[0]);
        end
      end
    end
  end

  // stimulus
  initial begin
    model_reset();
    do_reset();

    cycle(ENGINE_UP, DOOR_HOLD);
    settle();
    check("mid_init_up",    sensor_up[2], 0);
    check("mid_init_dn",    sensor_down[2], 0);
    check("mid_init_floor", car_floor[2], 0);
    check("rst_sensor_door", sensor_door[0], 2);
    check("rst_fault",      fault[0], 0);
    check("top_overtravel_fault", fault[1], 1);

    repeat (2) cycle(ENGINE_UP, DOOR_HOLD);
    settle();
    check("pos_before_first_step", car_pos[0], 0);
    cycle(ENGINE_UP, DOOR_HOLD);
    settle();
    check("first_step_clock4", car_pos[0], 1);

    repeat (3796) cycle(ENGINE_UP, DOOR_HOLD);
    settle();
    check("approach_pos", car_pos[0], 950);
    check("approach_up_lag", sensor_up[0], 0);
    cycle(ENGINE_UP, DOOR_HOLD);
    settle();
    check("approach_up", sensor_up[0], 1);
    check("approach_dn", sensor_down[0], 0);

    repeat (199) cycle(ENGINE_UP, DOOR_HOLD);
    settle();
    check("arrive_pos", car_pos[0], 1000);
    check("arrive_dn_lag", sensor_down[0], 0);
    cycle(ENGINE_STOP, DOOR_HOLD);
    settle();
    check("level_up",    sensor_up[0], 1);
    check("level_dn",    sensor_down[0], 1);
    check("level_floor", car_floor[0], 1);
    check("top_pos_held", car_pos[1], 7000);

    cycle(ENGINE_STOP, DOOR_OPEN);
    settle();
    check("door_leaves_closed", sensor_door[0], 0);
    repeat (599) cycle(ENGINE_STOP, DOOR_OPEN);
    settle();
    check("door_fully_open", sensor_door[0], 1);
    repeat (300) cycle(ENGINE_STOP, DOOR_CLOSE);
    cycle(ENGINE_STOP, DOOR_OPEN);
    settle();
    check("door_reverse_travel", sensor_door[0], 0);
    check("door_reverse_no_fault", fault[0], 0);

    repeat (101) cycle(ENGINE_STOP, DOOR_CLOSE);
    repeat (8) cycle(ENGINE_UP, DOOR_HOLD);
    settle();
    check("interlock_pos", car_pos[0], 1000);
    check("interlock_fault", fault[0], 1);
    check("interlock_door", sensor_door[0], 0);
    repeat (20) cycle(ENGINE_STOP, DOOR_HOLD);
    settle();
    check("fault_sticky", fault[0], 1);

    do_reset();
    cycle(ENGINE_STOP, DOOR_HOLD);
    settle();
    check("reset_clears_fault", fault[0], 0);
    check("reset_pos", car_pos[0], 0);
    check("reset_door", sensor_door[0], 2);

    for (int s = 0; s < 40; s++) begin
      int r, len;
      logic [1:0] e, d;
      if ($urandom_range(0, 9) == 0) do_reset();
      r = $urandom_range(0, 99);
      e = (r < 35) ? 2'b00 : (r < 65) ? 2'b01 : (r < 96) ? 2'b10 : 2'b11;
      r = $urandom_range(0, 99);
      d = (r < 40) ? 2'b00 : (r < 68) ? 2'b01 : (r < 97) ? 2'b10 : 2'b11;
      if ((e == 2'b01 || e == 2'b10) && $urandom_range(0, 1) == 1) d = 2'b00;
      len = $urandom_range(1, 200);
      repeat (len) cycle(e, d);
    end

    repeat (2) @(posedge clk);
    #4;
    check("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
